aim_step_driver: RTL and testbench

- Consumes the steering command stream (dir, val, done) from the audio intensity comparator.
- Converts each accepted command into a train of stepper-motor step pulses with a direction line.
- Tracks absolute aim position and stops at travel limits, so the sensor head turns toward the louder side.
- Sits between the audio tracking logic and the motor driver pins.

---
 rtl/aim_step_driver.sv | 124 ++++++++++++
 tb/tb_aim_step_driver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aim_step_driver.sv
// Stepper driver for the audio aim head: turns steering commands into
// step/direction pulse trains and tracks absolute head position.
module aim_step_driver #(
  parameter logic [15:0] STEP_PERIOD = 16'd50000,
  parameter logic [15:0] PULSE_WIDTH = 16'd100,
  parameter logic [11:0] POS_MAX     = 12'd2048,
  parameter logic [11:0] POS_CENTER  = 12'd1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dir,
  input  logic [7:0]  val,
  input  logic        done,
  output logic        step,
  output logic        motor_dir,
  output logic        busy,
  output logic        ack,
  output logic [11:0] pos,
  output logic        at_limit
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE_HI,
    PULSE_LO
  } state_t;

  localparam logic [15:0] HI_LAST = PULSE_WIDTH - 16'd1;
  localparam logic [15:0] LO_LAST = STEP_PERIOD - PULSE_WIDTH - 16'd1;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0]  rem, rem_n;
  logic [11:0] pos_n;
  logic        motor_dir_n;
  logic        ack_n;
  logic        at_limit_n;
  logic        check;
  logic        blocked;

  assign blocked = motor_dir ? (pos == 12'd0) : (pos == POS_MAX);
  assign step    = (state == PULSE_HI);
  assign busy    = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      pos       <= POS_CENTER;
      motor_dir <= 1'b0;
      ack       <= 1'b0;
      at_limit  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rem       <= rem_n;
      pos       <= pos_n;
      motor_dir <= motor_dir_n;
      ack       <= ack_n;
      at_limit  <= at_limit_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 16'd1;
    rem_n       = rem;
    pos_n       = pos;
    motor_dir_n = motor_dir;
    ack_n       = 1'b0;
    at_limit_n  = at_limit;
    check       = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        // gating on ack keeps a held done with val=0 from pulsing ack back to back
        if (done && !ack) begin
          ack_n = 1'b1;
          if (val != 8'd0) begin
            motor_dir_n = dir;
            rem_n       = val;
            at_limit_n  = 1'b0;
            state_n     = SETUP;
          end
        end
      end
      SETUP: begin
        check = 1'b1;
      end
      PULSE_HI: begin
        if (cnt == HI_LAST) begin
          pos_n   = motor_dir ? pos - 12'd1 : pos + 12'd1;
          rem_n   = rem - 8'd1;
          cnt_n   = '0;
          state_n = PULSE_LO;
        end
      end
      PULSE_LO: begin
        if (cnt == LO_LAST) begin
          if (rem == 8'd0) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            check = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (check) begin
      cnt_n = '0;
      if (blocked) begin
        state_n    = IDLE;
        at_limit_n = 1'b1;
        rem_n      = '0;
      end else begin
        state_n = PULSE_HI;
      end
    end
  end

endmodule

// File: tb/tb_aim_step_driver.sv
// Randomized scoreboard bench for aim_step_driver against a
// command-level model of position, pulse count and busy time.
module tb_aim_step_driver;

  localparam int SP   = 8;
  localparam int PW   = 2;
  localparam int PMAX = 20;
  localparam int PCTR = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dir = 1'b0;
  logic [7:0]  val = 8'd0;
  logic        done = 1'b0;
  logic        step;
  logic        motor_dir;
  logic        busy;
  logic        ack;
  logic [11:0] pos;
  logic        at_limit;

  aim_step_driver #(
    .STEP_PERIOD(16'd8),
    .PULSE_WIDTH(16'd2),
    .POS_MAX(12'd20),
    .POS_CENTER(12'd10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dir(dir),
    .val(val),
    .done(done),
    .step(step),
    .motor_dir(motor_dir),
    .busy(busy),
    .ack(ack),
    .pos(pos),
    .at_limit(at_limit)
  );

  always #5 clock = ~clock;

  typedef struct {
    int pulses;
    int pos;
    int lim;
    int blen;
    int mdir;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int mpos = PCTR;
  int mlim = 0;
  int mdir = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Whole-command outcome: steps taken until the limit, and the busy span.
  function automatic exp_t model(input int d, input int v);
    exp_t e;
    int room, n;
    if (v == 0) begin
      e = '{0, mpos, mlim, 0, mdir};
    end else begin
      room = d ? mpos : PMAX - mpos;
      n    = (v < room) ? v : room;
      mpos = d ? mpos - n : mpos + n;
      mlim = (v > room) ? 1 : 0;
      mdir = d;
      e    = '{n, mpos, mlim, 1 + n * SP, d};
    end
    return e;
  endfunction

  // Monitor: measures each command from its ack to busy falling.
  int  cyc = 0;
  bit  active = 0;
  bit  pbusy = 0, pack = 0, pstep = 0;
  int  ack_cyc, pulses, blen, last_rise, hi_len;

  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (reset) begin
      active = 0;
      pbusy  = 0;
      pack   = 0;
      pstep  = 0;
    end else begin
      if (step && !busy) chk("step_idle", 1, 0);
      if (ack && pack) chk("ack_twice", 1, 0);
      if (ack) begin
        if (active && pbusy) chk("ack_busy", 1, 0);
        active  = 1;
        ack_cyc = cyc;
        pulses  = 0;
        blen    = 0;
        hi_len  = 0;
      end
      if (active) begin
        if (busy) blen++;
        if (step && !pstep) begin
          pulses++;
          if (pulses == 1) chk("first_rise", cyc - ack_cyc, 1);
          else chk("period", cyc - last_rise, SP);
          last_rise = cyc;
          hi_len = 1;
        end else if (step) begin
          hi_len++;
        end else if (pstep) begin
          chk("pulse_w", hi_len, PW);
        end
        if (!busy) begin
          if (q.size() == 0) begin
            chk("sb_empty", 1, 0);
          end else begin
            e = q.pop_front();
            chk("pulses", pulses, e.pulses);
            chk("pos", int'(pos), e.pos);
            chk("at_limit", int'(at_limit), e.lim);
            chk("busy_len", blen, e.blen);
            chk("motor_dir", int'(motor_dir), e.mdir);
          end
          active = 0;
        end
      end
      pbusy = busy;
      pack  = ack;
      pstep = step;
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 3000) begin
      @(posedge clock); #1;
      k++;
    end
    if (k >= 3000) chk("idle_wait", 1, 0);
  endtask

  task automatic send(input int d, input int v, input bit poke);
    exp_t e;
    @(posedge clock); #1;
    wait_idle();
    dir  = d[0];
    val  = v[7:0];
    done = 1'b1;
    e = model(d, v);
    q.push_back(e);
    @(posedge clock); #1;
    done = 1'b0;
    chk("ack_t1", int'(ack), 1);
    chk("busy_t1", int'(busy), (v != 0) ? 1 : 0);
    if (poke && e.blen >= 9) begin
      repeat (3) @(posedge clock);
      #1;
      dir  = $urandom_range(1, 0);
      val  = 8'($urandom_range(255, 1));
      done = 1'b1;
      @(posedge clock); #1;
      done = 1'b0;
    end
  endtask

  task automatic hold_cmd();
    @(posedge clock); #1;
    wait_idle();
    dir  = 1'b0;
    val  = 8'd3;
    done = 1'b1;
    q.push_back(model(0, 3));
    @(posedge clock); #1;
    chk("hold_ack", int'(ack), 1);
    repeat (5) @(posedge clock);
    #1;
    val = 8'd7;
    wait_idle();
    q.push_back(model(0, 7));
    @(posedge clock); #1;
    done = 1'b0;
    chk("hold_ack2", int'(ack), 1);
  endtask

  task automatic reset_mid();
    int k = 0;
    int rises = 0;
    bit ps = 0;
    send(0, 5, 0);
    while (rises < 2 && k < 200) begin
      if (step && !ps) rises++;
      ps = step;
      if (rises < 2) begin
        @(posedge clock); #1;
      end
      k++;
    end
    if (k >= 200) chk("rise_wait", 1, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    q.delete();
    mpos = PCTR;
    mlim = 0;
    mdir = 0;
    chk("rst_step", int'(step), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pos", int'(pos), PCTR);
    k = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (step) k++;
    end
    chk("rst_quiet", k, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("r_step", int'(step), 0);
    chk("r_busy", int'(busy), 0);
    chk("r_ack", int'(ack), 0);
    chk("r_lim", int'(at_limit), 0);
    chk("r_mdir", int'(motor_dir), 0);
    chk("r_pos", int'(pos), PCTR);

    send(0, 3, 0);
    send(0, 0, 0);
    hold_cmd();
    send(1, 2, 0);
    reset_mid();
    send(0, 15, 0);
    send(1, 2, 0);
    for (int i = 0; i < 24; i++) begin
      send(int'($urandom_range(1, 0)), int'($urandom_range(12, 0)),
           1'($urandom_range(1, 0)));
    end
    @(posedge clock); #1;
    wait_idle();
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
